// File: rtl/clock_freq_meter_if.sv
// Result and control bundle for clock_freq_meter: the user side drives enable and
// the clock under test; the meter drives the measurement results and its state.
interface clock_freq_meter_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             meas_clk;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             busy;
    logic             overflow;
    logic             clk_alive;
    logic [1:0]       dbg_state;

    // valid is a one-cycle strobe with no back-pressure; count, overflow and
    // clk_alive are stable from that strobe until the next one.
    modport master (
        output enable, meas_clk,
        input  count, valid, busy, overflow, clk_alive, dbg_state
    );

    modport slave (
        input  enable, meas_clk,
        output count, valid, busy, overflow, clk_alive, dbg_state
    );
endinterface

// File: rtl/clock_freq_meter.sv
// Counts rising edges of an asynchronous clock over a fixed window of clk cycles
// and publishes the count, a saturation flag and a clock-alive flag per window.
module clock_freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rstn,
    clock_freq_meter_if.slave mif
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_GATE = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   edge_det;

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edges_q, edges_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             alive_q, alive_d;

    assign edge_det = sync_q[SYNC_STAGES-1] & ~edge_q;

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edges_d = edges_q;
        sat_d   = sat_q;
        count_d = count_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        alive_d = alive_q;
        case (state_q)
            S_IDLE: begin
                if (mif.enable) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                edges_d = '0;
                sat_d   = 1'b0;
                gate_d  = GATE_LOAD;
                state_d = mif.enable ? S_GATE : S_IDLE;
            end
            S_GATE: begin
                if (!mif.enable) begin
                    state_d = S_IDLE;
                end else begin
                    if (edge_det) begin
                        if (edges_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            edges_d = edges_q + CNT_W'(1);
                        end
                    end
                    if (gate_q == '0) begin
                        // Results are registered on entry to DONE so that the
                        // strobe and the new count appear in the same cycle,
                        // including an edge seen on the final gate cycle.
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        count_d = edges_d;
                        ovf_d   = sat_d;
                        alive_d = (edges_d != '0);
                    end else begin
                        gate_d = gate_q - GW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = mif.enable ? S_ARM : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            state_q <= S_IDLE;
            gate_q  <= '0;
            edges_q <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], mif.meas_clk};
            edge_q  <= sync_q[SYNC_STAGES-1];
            state_q <= state_d;
            gate_q  <= gate_d;
            edges_q <= edges_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            alive_q <= alive_d;
        end
    end

    assign mif.count     = count_q;
    assign mif.valid     = valid_q;
    assign mif.busy      = (state_q == S_ARM) || (state_q == S_GATE);
    assign mif.overflow  = ovf_q;
    assign mif.clk_alive = alive_q;
    assign mif.dbg_state = state_q;

endmodule

// File: tb/tb_clock_freq_meter.sv
// Bench for clock_freq_meter: random and directed meas_clk rates against an
// arithmetic window model, dead clock, abort, saturation and async reset.
module tb_clock_freq_meter;

    localparam int GATE    = 100;
    localparam int CLK_NS  = 10;
    localparam int WIN_NS  = GATE * CLK_NS;
    localparam int PERIOD  = GATE + 2;
    localparam int MAX_A   = 65535;
    localparam int MAX_B   = 15;
    localparam int TIMEOUT = 400;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    clock_freq_meter_if #(.CNT_W(16)) if_a ();
    clock_freq_meter_if #(.CNT_W(4))  if_b ();

    clock_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16), .SYNC_STAGES(2)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .mif  (if_a)
    );

    clock_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) u_sat (
        .clk  (clk),
        .rstn (rstn),
        .mif  (if_b)
    );

    // ---------------- clock / reset / stimulus sources ----------------
    always #5 clk = ~clk;

    // meas_clk toggles only at times 2 mod 5, never on a clk rising edge.
    int   meas_half = 0;
    logic meas_stop = 1'b0;
    logic meas      = 1'b0;

    initial begin
        #2;
        forever begin
            if (meas_half == 0) begin
                meas = meas_stop;
                #5;
            end else begin
                #(meas_half) meas = ~meas;
            end
        end
    end

    assign if_a.meas_clk = meas;
    assign if_b.meas_clk = meas;

    // ---------------- checking and scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edges of a period-per_ns clock inside any window of WIN_NS: floor or ceil
    // of WIN_NS/per_ns, limited by the counter ceiling.
    function automatic int exp_count(input int got, input int per_ns, input int max_cnt);
        int lo, hi;
        if (per_ns == 0) return 0;
        lo = WIN_NS / per_ns;
        hi = (WIN_NS + per_ns - 1) / per_ns;
        if (lo > max_cnt) lo = max_cnt;
        if (hi > max_cnt) hi = max_cnt;
        return (got == hi) ? hi : lo;
    endfunction

    function automatic int exp_ovf(input int per_ns, input int max_cnt);
        if (per_ns == 0) return 0;
        return ((WIN_NS / per_ns) > max_cnt) ? 1 : 0;
    endfunction

    // ---------------- driver / monitor tasks ----------------
    task automatic wait_valid(input bit use_b, output int cycles);
        logic v;
        cycles = 0;
        v = 1'b0;
        while (!v && cycles < TIMEOUT) begin
            @(posedge clk);
            #1;
            cycles++;
            v = use_b ? if_b.valid : if_a.valid;
        end
        if (!v) check("valid_timeout", 32'(v), 1);
    endtask

    task automatic next_result(input bit use_b, input string tag);
        int cyc;
        exp_q.push_back(PERIOD);
        wait_valid(use_b, cyc);
        check({tag, "_lat"}, cyc, exp_q.pop_front());
    endtask

    task automatic check_a(input string tag, input int per_ns);
        int got, e;
        got = int'(if_a.count);
        e = exp_count(got, per_ns, MAX_A);
        check({tag, "_cnt"}, got, e);
        check({tag, "_alive"}, 32'(if_a.clk_alive), (e != 0) ? 1 : 0);
        check({tag, "_ovf"}, 32'(if_a.overflow), exp_ovf(per_ns, MAX_A));
    endtask

    task automatic check_b(input string tag, input int per_ns);
        int got, e;
        got = int'(if_b.count);
        e = exp_count(got, per_ns, MAX_B);
        check({tag, "_cnt"}, got, e);
        check({tag, "_alive"}, 32'(if_b.clk_alive), (e != 0) ? 1 : 0);
        check({tag, "_ovf"}, 32'(if_b.overflow), exp_ovf(per_ns, MAX_B));
    endtask

    task automatic set_period(input int per_ns);
        meas_half = per_ns / 2;
    endtask

    task automatic stop_a();
        @(negedge clk);
        if_a.enable = 1'b0;
        @(posedge clk);
        #1;
        check("stop_state", 32'(if_a.dbg_state), 0);
        check("stop_busy", 32'(if_a.busy), 0);
    endtask

    // ---------------- main sequence ----------------
    int rates[8];
    int nv;
    int k;

    initial begin
        if_a.enable = 1'b0;
        if_b.enable = 1'b0;
        rates[0] = 80;
        rates[1] = 40;
        rates[2] = 20;
        rates[3] = 30;
        for (int i = 4; i < 8; i++) rates[i] = 10 * $urandom_range(2, 40);

        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 32'(if_a.count), 0);
        check("rst_valid", 32'(if_a.valid), 0);
        check("rst_busy", 32'(if_a.busy), 0);
        check("rst_ovf", 32'(if_a.overflow), 0);
        check("rst_alive", 32'(if_a.clk_alive), 0);
        check("rst_state", 32'(if_a.dbg_state), 0);
        check("rst_count_b", 32'(if_b.count), 0);
        @(negedge clk) rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_state", 32'(if_a.dbg_state), 0);
        check("idle_busy", 32'(if_a.busy), 0);

        // Rates: first result latency, continuous period, and count range.
        for (int i = 0; i < 8; i++) begin
            set_period(rates[i]);
            repeat (10) @(negedge clk);
            if_a.enable = 1'b1;
            next_result(1'b0, "rate_first");
            check_a("rate_w1", rates[i]);
            @(negedge clk);
            check("rate_busy_done", 32'(if_a.busy), 0);
            next_result(1'b0, "rate_next");
            check_a("rate_w2", rates[i]);
            stop_a();
        end

        // Dead clock for three windows, then revive.
        meas_stop = 1'b0;
        set_period(0);
        repeat (20) @(negedge clk);
        if_a.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_result(1'b0, "dead");
            check_a("dead", 0);
        end
        set_period(40);
        next_result(1'b0, "revive");
        check("revive_alive", 32'(if_a.clk_alive), 1);
        check("revive_nonzero", (if_a.count != 0) ? 1 : 0, 1);
        next_result(1'b0, "revive_full");
        check_a("revive_full", 40);
        meas_stop = 1'b1;
        set_period(0);
        next_result(1'b0, "stop_hi_edge");
        next_result(1'b0, "stop_hi");
        check_a("stop_hi", 0);
        stop_a();

        // Abort in the middle of GATE: no result, previous result kept.
        set_period(100);
        repeat (10) @(negedge clk);
        if_a.enable = 1'b1;
        next_result(1'b0, "pre_abort");
        check_a("pre_abort", 100);
        k = $urandom_range(20, 80);
        repeat (k) @(negedge clk);
        if_a.enable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(if_a.busy), 0);
        check("abort_state", 32'(if_a.dbg_state), 0);
        nv = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(posedge clk);
            #1;
            if (if_a.valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        check("abort_hold_cnt", 32'(if_a.count), WIN_NS / 100);
        check("abort_hold_alive", 32'(if_a.clk_alive), 1);
        @(negedge clk);
        if_a.enable = 1'b1;
        next_result(1'b0, "after_abort");
        check_a("after_abort", 100);

        // Asynchronous reset between clk edges in the middle of GATE.
        repeat (40) @(posedge clk);
        #3;
        if_a.enable = 1'b0;
        rstn = 1'b0;
        #1;
        check("arst_count", 32'(if_a.count), 0);
        check("arst_busy", 32'(if_a.busy), 0);
        check("arst_alive", 32'(if_a.clk_alive), 0);
        check("arst_valid", 32'(if_a.valid), 0);
        check("arst_state", 32'(if_a.dbg_state), 0);
        @(negedge clk) rstn = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (if_a.busy || if_a.valid) nv++;
        end
        check("arst_stays_idle", nv, 0);
        @(negedge clk);
        if_a.enable = 1'b1;
        next_result(1'b0, "post_rst");
        check_a("post_rst", 100);
        stop_a();

        // Saturation with a 4-bit counter, then a slow clock that fits.
        set_period(40);
        repeat (10) @(negedge clk);
        if_b.enable = 1'b1;
        next_result(1'b1, "sat");
        check_b("sat", 40);
        set_period(400);
        next_result(1'b1, "sat_edge");
        next_result(1'b1, "slow");
        check_b("slow", 400);
        @(negedge clk);
        if_b.enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
